xif_copro_issue_stage: RTL and testbench
========================================

Name: xif_copro_issue_stage

Overview:
- Front end of the XIF coprocessor: the transmitter side of the execution-stage handshake.
- Receives offloaded instructions on the XIF issue interface and decodes them into copro operations.
- Holds each accepted instruction in an in-order buffer until the core commits or kills it.
- Dispatches committed instructions, with operands, operator and tag, to the execution stage over a valid/ready handshake.

Parameters:
XLEN, 64, operand width.
ID_WIDTH, 4, width of the XIF instruction id.
DEPTH, 2, buffer entries; power of two, at least 2.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, synchronous, active-low.
issue_valid_i  in  1  XIF issue request valid.
issue_ready_o  out  1  XIF issue request ready.
issue_instr_i  in  32  offloaded instruction word.
issue_id_i  in  ID_WIDTH  instruction id.
issue_rs1_i  in  XLEN  rs1 value.
issue_rs2_i  in  XLEN  rs2 value.
issue_rs_valid_i  in  2  [0] rs1 valid, [1] rs2 valid.
issue_accept_o  out  1  instruction is accepted by the coprocessor.
issue_writeback_o  out  1  instruction will write rd.
commit_valid_i  in  1  commit/kill strobe.
commit_id_i  in  ID_WIDTH  id being committed or killed.
commit_kill_i  in  1  1 = kill, 0 = commit.
ex_valid_o  out  1  dispatch valid to the execution stage.
ex_ready_i  in  1  execution stage ready.
ex_operand_a_o  out  XLEN  rs1 of the dispatched entry.
ex_operand_b_o  out  XLEN  rs2 of the dispatched entry.
ex_operator_o  out  xif_copro_pkg::copro_op_e  decoded operator.
ex_tag_o  out  ID_WIDTH+5  {id, rd} of the dispatched entry.

Behaviour:
- Decode (combinational):
  - opcode[6:0]=7'b0001011, funct3=3'b000, funct7=7'b0000000 -> BITREV.
  - Any other word -> NONE (not recognised).
  - BITREV requires rs1 only; rs2 is captured as presented.
- Issue handshake on issue_valid_i & issue_ready_o:
  - Recognised and count<DEPTH and issue_rs_valid_i[0]=1: issue_ready_o=1, issue_accept_o=1, issue_writeback_o=1; push an entry {id, rd=instr[11:7], op, rs1, rs2, committed=0, killed=0}.
  - Recognised but buffer full or rs1 not valid: issue_ready_o=0, accept=0; the core holds the request.
  - Not recognised: issue_ready_o=1, issue_accept_o=0, issue_writeback_o=0; nothing is stored.
  - When issue_valid_i=0: issue_ready_o, issue_accept_o and issue_writeback_o are all 0.
- Buffer:
  - Circular; head/tail pointers of log2(DEPTH) bits that wrap at DEPTH; count of log2(DEPTH)+1 bits.
  - At most one push and one pop per cycle.
  - Push is gated by count<DEPTH only; a same-cycle pop does not free a slot.
- Commit:
  - On commit_valid_i, every valid entry whose id equals commit_id_i gets committed=1, or killed=1 if commit_kill_i=1.
  - A commit/kill that targets the entry pushed in the same cycle is applied to that new entry.
  - A commit for an id not present, or a repeat commit, is ignored.
  - Commit after kill is ignored; kill after commit is a core protocol violation and is not checked.
- Head control:
  - Head valid & killed: popped with no dispatch, one per cycle; ex_valid_o=0 that cycle.
  - Head valid & committed & ~killed: ex_valid_o=1; ex_* outputs are driven combinationally from the head entry.
  - Pop on ex_valid_o & ex_ready_i.
  - ex_* outputs stay stable while ex_valid_o=1 and ex_ready_i=0.
  - Latency: an entry committed in cycle N (or pushed and committed in cycle N) produces ex_valid_o in cycle N+1 at the earliest.
- Ordering: strictly in order; a committed younger entry waits behind an uncommitted head.
- Reset: rst_ni=0 at a rising edge clears all entries, pointers and count, including mid-operation with entries pending.
  - While the buffer is empty: ex_valid_o=0, ex_operand_a_o=0, ex_operand_b_o=0, ex_operator_o=NONE, ex_tag_o=0.
  - Issue outputs follow the decode rules above.

Test Plan:
- Single BITREV: instr 32'h0005028B, id 3, rs1 64'h1, rs_valid 2'b01 -> ready=1, accept=1, writeback=1; commit id 3 the next cycle -> ex_valid_o=1 one cycle later with operand_a=64'h1, operator=BITREV, ex_tag_o={4'd3, 5'd5}; pop when ex_ready_i=1.
- Reject: instr 32'h00000033 -> ready=1, accept=0, writeback=0; the count stays 0.
- Full and backpressure (DEPTH=2): issue ids 1 and 2, then id 3 -> issue_ready_o=0 until an entry pops. Commit 1 and 2 with ex_ready_i=0 for 3 cycles -> ex outputs hold id 1 stable.
- Kill: issue ids 4 and 5, kill 4, commit 5 -> id 4 is dropped without dispatch; id 5 is dispatched the following cycle.
- Same-cycle push and commit of id 6 -> dispatched the next cycle. Wrap-around: 5 sequential instructions pass through DEPTH=2 in order.
- Reset with 2 committed entries pending and ex_ready_i=0 -> after reset ex_valid_o=0 and count=0; a new issue is accepted immediately.

Source files
------------

// File: rtl/xif_copro_issue_stage.sv
// xif_copro_issue_stage
//   Front end of the XIF coprocessor. Decodes offloaded instructions, holds
//   accepted ones in an in-order buffer until the core commits or kills them,
//   then hands committed entries to the execution stage (valid/ready).
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   issue_*                   XIF issue request / response
//   commit_*                  XIF commit/kill strobe
//   ex_valid_o, ex_ready_i    dispatch handshake to the execution stage
//   ex_operand_{a,b}_o        rs1 / rs2 of the head entry
//   ex_operator_o, ex_tag_o   decoded op and {id, rd} of the head entry

package xif_copro_pkg;
  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_BITREV = 2'd1
  } copro_op_e;
endpackage

module xif_copro_issue_stage
  import xif_copro_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [XLEN-1:0]       issue_rs2_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [XLEN-1:0]       ex_operand_a_o,
  output logic [XLEN-1:0]       ex_operand_b_o,
  output copro_op_e             ex_operator_o,
  output logic [ID_WIDTH+4:0]   ex_tag_o
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    copro_op_e           op;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic                committed;
    logic                killed;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW:0]        count_q, count_d;

  // rs1/rs2 register fields and rs2-valid play no part in this op set.
  logic unused_ok;
  assign unused_ok = ^{issue_instr_i[24:15], issue_rs_valid_i[1]};

  // Decode
  copro_op_e dec_op;
  logic      dec_ok;
  always_comb begin
    dec_op = OP_NONE;
    if (issue_instr_i[6:0] == 7'b0001011 && issue_instr_i[14:12] == 3'b000 &&
        issue_instr_i[31:25] == 7'b0000000)
      dec_op = OP_BITREV;
  end
  assign dec_ok = (dec_op != OP_NONE);

  // Issue handshake. Unrecognised words are consumed (ready=1) but rejected;
  // recognised ones stall until there is a free slot and rs1 is available.
  logic has_room, push;
  assign has_room          = (count_q < (PW+1)'(DEPTH));
  assign push              = issue_valid_i & dec_ok & has_room & issue_rs_valid_i[0];
  assign issue_accept_o    = push;
  assign issue_writeback_o = push;
  assign issue_ready_o     = issue_valid_i & (~dec_ok | (has_room & issue_rs_valid_i[0]));

  // Head control
  entry_t head;
  logic   nonempty, kill_pop, pop;
  assign head       = ent_q[head_q];
  assign nonempty   = (count_q != '0);
  assign kill_pop   = nonempty & head.killed;
  assign ex_valid_o = nonempty & head.committed & ~head.killed;
  assign pop        = kill_pop | (ex_valid_o & ex_ready_i);

  assign ex_operand_a_o = ex_valid_o ? head.rs1 : '0;
  assign ex_operand_b_o = ex_valid_o ? head.rs2 : '0;
  assign ex_operator_o  = ex_valid_o ? head.op : OP_NONE;
  assign ex_tag_o       = ex_valid_o ? {head.id, head.rd} : '0;

  // Slot occupancy derived from head/count so no per-entry valid flop is needed.
  logic [DEPTH-1:0] slot_vld;
  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++)
      slot_vld[i] = ({1'b0, PW'(i) - head_q} < count_q);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    // Commit/kill every live entry with a matching id; a killed entry is final.
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && slot_vld[i] && ent_q[i].id == commit_id_i && !ent_q[i].killed) begin
        if (commit_kill_i) ent_d[i].killed    = 1'b1;
        else               ent_d[i].committed = 1'b1;
      end
    end

    // The pushed slot is free, so no commit above can collide with it.
    if (push) begin
      ent_d[tail_q].id        = issue_id_i;
      ent_d[tail_q].rd        = issue_instr_i[11:7];
      ent_d[tail_q].op        = dec_op;
      ent_d[tail_q].rs1       = issue_rs1_i;
      ent_d[tail_q].rs2       = issue_rs2_i;
      ent_d[tail_q].committed = commit_valid_i & (commit_id_i == issue_id_i) & ~commit_kill_i;
      ent_d[tail_q].killed    = commit_valid_i & (commit_id_i == issue_id_i) &  commit_kill_i;
      tail_d = tail_q + PW'(1);
    end

    if (pop) head_d = head_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_xif_copro_issue_stage.sv
module tb_xif_copro_issue_stage;
  import xif_copro_pkg::*;
  localparam int XLEN = 64, IDW = 4, DEPTH = 2;

  logic            clk_i = 1'b0, rst_ni;
  logic            issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0]     issue_instr_i;
  logic [IDW-1:0]  issue_id_i, commit_id_i;
  logic [XLEN-1:0] issue_rs1_i, issue_rs2_i, ex_operand_a_o, ex_operand_b_o;
  logic [1:0]      issue_rs_valid_i;
  logic            commit_valid_i, commit_kill_i, ex_valid_o, ex_ready_i;
  copro_op_e       ex_operator_o;
  logic [IDW+4:0]  ex_tag_o;

  int checks = 0, errors = 0;

  xif_copro_issue_stage #(.XLEN(XLEN), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
    .ex_operator_o(ex_operator_o), .ex_tag_o(ex_tag_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  function automatic logic [31:0] bitrev_instr(input logic [4:0] rd);
    return {7'b0, 5'd0, 5'd10, 3'b000, rd, 7'b0001011};
  endfunction

  task automatic issue(input logic [IDW-1:0] id, input logic [4:0] rd, input logic [XLEN-1:0] rs1);
    issue_valid_i = 1'b1; issue_instr_i = bitrev_instr(rd); issue_id_i = id;
    issue_rs1_i = rs1; issue_rs2_i = ~rs1; issue_rs_valid_i = 2'b01;
  endtask

  task automatic commit(input logic [IDW-1:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  task automatic idle_all();
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0; issue_rs1_i = '0;
    issue_rs2_i = '0; issue_rs_valid_i = 2'b00;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0; ex_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; idle_all(); step(); step();
    rst_ni = 1'b1; #1;
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid_o); end
    checks++; if ({ex_operand_a_o, ex_operand_b_o, ex_tag_o} !== '0) begin errors++; $display("FAIL reset_ex_data got %h/%h/%h want 0", ex_operand_a_o, ex_operand_b_o, ex_tag_o); end
    checks++; if (ex_operator_o !== OP_NONE) begin errors++; $display("FAIL reset_operator got %0d want NONE", ex_operator_o); end
    checks++; if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b000) begin errors++; $display("FAIL reset_issue_out got %b want 000", {issue_ready_o, issue_accept_o, issue_writeback_o}); end
    checks++; if (dut.count_q !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_single();
    issue_valid_i = 1'b1; issue_instr_i = 32'h0005028B; issue_id_i = 4'd3;
    issue_rs1_i = 64'h1; issue_rs2_i = 64'hABCD; issue_rs_valid_i = 2'b01; #1;
    checks++; if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b111) begin errors++; $display("FAIL single_issue got %b want 111", {issue_ready_o, issue_accept_o, issue_writeback_o}); end
    step(); idle_all(); commit(4'd3, 1'b0); #1;
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", ex_valid_o); end
    step(); idle_all(); #1;
    checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL single_ex_valid got %0b want 1", ex_valid_o); end
    checks++; if (ex_operand_a_o !== 64'h1 || ex_operand_b_o !== 64'hABCD) begin errors++; $display("FAIL single_operands got %h/%h want 1/abcd", ex_operand_a_o, ex_operand_b_o); end
    checks++; if (ex_operator_o !== OP_BITREV) begin errors++; $display("FAIL single_operator got %0d want BITREV", ex_operator_o); end
    checks++; if (ex_tag_o !== {4'd3, 5'd5}) begin errors++; $display("FAIL single_tag got %h want %h", ex_tag_o, {4'd3, 5'd5}); end
    ex_ready_i = 1'b1; step(); ex_ready_i = 1'b0; #1;
    checks++; if (ex_valid_o !== 1'b0 || dut.count_q !== '0) begin errors++; $display("FAIL single_pop got v=%0b cnt=%0d want 0/0", ex_valid_o, dut.count_q); end
  endtask

  task automatic test_reject();
    issue_valid_i = 1'b1; issue_instr_i = 32'h00000033; issue_id_i = 4'd2; issue_rs_valid_i = 2'b11; #1;
    checks++; if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b100) begin errors++; $display("FAIL reject_issue got %b want 100", {issue_ready_o, issue_accept_o, issue_writeback_o}); end
    step();
    // recognised but rs1 not valid: held off
    issue(4'd2, 5'd1, 64'h5); issue_rs_valid_i = 2'b10; #1;
    checks++; if ({issue_ready_o, issue_accept_o} !== 2'b00) begin errors++; $display("FAIL rs1_invalid got %b want 00", {issue_ready_o, issue_accept_o}); end
    step(); idle_all(); #1;
    checks++; if (dut.count_q !== '0) begin errors++; $display("FAIL reject_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_full_backpressure();
    issue(4'd1, 5'd1, 64'd1); step();
    issue(4'd2, 5'd2, 64'd2); step();
    issue(4'd3, 5'd3, 64'd3); commit(4'd1, 1'b0); #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", issue_ready_o); end
    step(); commit(4'd2, 1'b0);
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {4'd1, 5'd1} || ex_operand_a_o !== 64'd1) begin errors++; $display("FAIL hold_id1[%0d] got v=%0b tag=%h a=%h want 1/%h/1", j, ex_valid_o, ex_tag_o, ex_operand_a_o, {4'd1, 5'd1}); end
      checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %0b want 0", j, issue_ready_o); end
      step(); commit_valid_i = 1'b0;
    end
    ex_ready_i = 1'b1; #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL pop_no_free got %0b want 0", issue_ready_o); end
    step(); #1;
    checks++; if (issue_ready_o !== 1'b1 || issue_accept_o !== 1'b1) begin errors++; $display("FAIL after_pop_ready got %b want 11", {issue_ready_o, issue_accept_o}); end
    checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {4'd2, 5'd2}) begin errors++; $display("FAIL dispatch_id2 got v=%0b tag=%h want 1/%h", ex_valid_o, ex_tag_o, {4'd2, 5'd2}); end
    step(); idle_all(); commit(4'd3, 1'b0); step(); commit_valid_i = 1'b0; #1;
    checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {4'd3, 5'd3} || ex_operand_a_o !== 64'd3) begin errors++; $display("FAIL dispatch_id3 got v=%0b tag=%h a=%h want 1/%h/3", ex_valid_o, ex_tag_o, ex_operand_a_o, {4'd3, 5'd3}); end
    ex_ready_i = 1'b1; step(); ex_ready_i = 1'b0; #1;
    checks++; if (dut.count_q !== '0) begin errors++; $display("FAIL full_drain_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_kill();
    issue(4'd4, 5'd4, 64'd4); step();
    issue(4'd5, 5'd5, 64'd5); step();
    idle_all(); commit(4'd4, 1'b1); step();
    commit(4'd5, 1'b0); #1;
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL kill_no_dispatch got %0b want 0", ex_valid_o); end
    step(); commit_valid_i = 1'b0; ex_ready_i = 1'b1; #1;
    checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {4'd5, 5'd5}) begin errors++; $display("FAIL kill_next_id5 got v=%0b tag=%h want 1/%h", ex_valid_o, ex_tag_o, {4'd5, 5'd5}); end
    step(); ex_ready_i = 1'b0; #1;
    checks++; if (dut.count_q !== '0) begin errors++; $display("FAIL kill_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_same_cycle();
    issue(4'd6, 5'd6, 64'd6); commit(4'd6, 1'b0); #1;
    checks++; if (ex_valid_o !== 1'b0 || issue_accept_o !== 1'b1) begin errors++; $display("FAIL same_cycle_issue got v=%0b acc=%0b want 0/1", ex_valid_o, issue_accept_o); end
    step(); idle_all(); #1;
    checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {4'd6, 5'd6}) begin errors++; $display("FAIL same_cycle_dispatch got v=%0b tag=%h want 1/%h", ex_valid_o, ex_tag_o, {4'd6, 5'd6}); end
    ex_ready_i = 1'b1; step(); ex_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [IDW-1:0] pid;
    for (int k = 0; k < 5; k++) begin
      issue(IDW'(7 + k), 5'(k + 1), 64'(100 + k)); commit(IDW'(7 + k), 1'b0); ex_ready_i = 1'b1; #1;
      checks++; if (issue_accept_o !== 1'b1) begin errors++; $display("FAIL wrap_accept[%0d] got %0b want 1", k, issue_accept_o); end
      if (k > 0) begin
        pid = IDW'(6 + k);
        checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {pid, 5'(k)} || ex_operand_a_o !== 64'(99 + k)) begin errors++; $display("FAIL wrap_order[%0d] got v=%0b tag=%h a=%0d want 1/%h/%0d", k, ex_valid_o, ex_tag_o, ex_operand_a_o, {pid, 5'(k)}, 99 + k); end
      end
      step();
    end
    idle_all(); ex_ready_i = 1'b1; #1;
    checks++; if (ex_valid_o !== 1'b1 || ex_tag_o !== {4'd11, 5'd5}) begin errors++; $display("FAIL wrap_last got v=%0b tag=%h want 1/%h", ex_valid_o, ex_tag_o, {4'd11, 5'd5}); end
    step(); ex_ready_i = 1'b0; #1;
    checks++; if (dut.count_q !== '0) begin errors++; $display("FAIL wrap_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_reset_mid();
    issue(4'd1, 5'd1, 64'd1); step();
    issue(4'd2, 5'd2, 64'd2); commit(4'd1, 1'b0); step();
    idle_all(); commit(4'd2, 1'b0); step(); commit_valid_i = 1'b0; #1;
    checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b want 1", ex_valid_o); end
    rst_ni = 1'b0; step(); rst_ni = 1'b1; #1;
    checks++; if (ex_valid_o !== 1'b0 || dut.count_q !== '0) begin errors++; $display("FAIL mid_reset got v=%0b cnt=%0d want 0/0", ex_valid_o, dut.count_q); end
    checks++; if (ex_tag_o !== '0 || ex_operand_a_o !== '0) begin errors++; $display("FAIL mid_reset_data got tag=%h a=%h want 0", ex_tag_o, ex_operand_a_o); end
    issue(4'd9, 5'd9, 64'd9); #1;
    checks++; if (issue_accept_o !== 1'b1 || issue_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_accept got %b want 11", {issue_ready_o, issue_accept_o}); end
    step(); idle_all(); #1;
    checks++; if (dut.count_q !== 2'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", dut.count_q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_full_backpressure();
    test_kill();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
